// File: rtl/multi_multiplier.sv
// Batch dispatcher for IEEE754 single-precision multiplication: NUM_UNITS operand pairs in, products out one per cycle in lane order.
// Build option MULT_PARALLEL_START_EN: start every unit on the acceptance edge instead of one unit per cycle.

module verilog_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res,
  output logic        done
);

  typedef enum logic [1:0] {
    U_IDLE = 2'd0,
    U_BUSY = 2'd1,
    U_DONE = 2'd2
  } ustate_t;

  ustate_t            st_r, st_n;
  logic [47:0]        acc_r, acc_n;
  logic [47:0]        mcand_r, mcand_n;
  logic [23:0]        mplier_r, mplier_n;
  logic               sign_r, sign_n;
  logic signed [9:0]  exp_r, exp_n;
  logic               special_r, special_n;
  logic [31:0]        res_r, res_n;
  logic [4:0]         tz_s;
  logic [32:0]        sp_s;
  logic [23:0]        ma_s, mb_s;

  // Index of the lowest set bit; multiplier trailing zeros are skipped, so latency depends on the operand.
  function automatic logic [4:0] tz24(input logic [23:0] m);
    logic [4:0] t;
    t = 5'd0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) t = 5'(i);
      else      t = t;
    end
    return t;
  endfunction

  // Zero, infinity and NaN operands bypass the mantissa loop; subnormals are flushed to zero.
  function automatic logic [32:0] fp_special(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi, xz, yz, s;
    logic [32:0] r;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    if (xn || yn || (xi && yz) || (xz && yi)) r = {1'b1, 32'h7FC00000};
    else if (xi || yi)                        r = {1'b1, s, 8'hFF, 23'h0};
    else if (xz || yz)                        r = {1'b1, s, 31'h0};
    else                                      r = {1'b0, 32'h0};
    return r;
  endfunction

  // Normalise a 48-bit mantissa product, round to nearest even, and saturate to inf / flush to zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e, input logic [47:0] p);
    logic [22:0]       m;
    logic              g, st;
    logic signed [9:0] ex;
    logic [23:0]       mr;
    logic [31:0]       r;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; ex = e + 10'sd1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0]; ex = e;
    end
    mr = {1'b0, m} + {23'h0, (g & (st | m[0]))};
    if (mr[23]) ex = ex + 10'sd1;
    else        ex = ex;
    if (ex >= 10'sd255)   r = {s, 8'hFF, 23'h0};
    else if (ex <= 10'sd0) r = {s, 31'h0};
    else                   r = {s, ex[7:0], mr[22:0]};
    return r;
  endfunction

  assign ma_s = {1'b1, a[22:0]};
  assign mb_s = {1'b1, b[22:0]};
  assign tz_s = tz24(mb_s);
  assign sp_s = fp_special(a, b);
  assign res  = res_r;
  assign done = (st_r == U_DONE);

  // Unit sequencing: done is held while ready stays high, and drops one cycle after ready is released.
  always_comb begin
    st_n      = st_r;
    acc_n     = acc_r;
    mcand_n   = mcand_r;
    mplier_n  = mplier_r;
    sign_n    = sign_r;
    exp_n     = exp_r;
    special_n = special_r;
    res_n     = res_r;
    case (st_r)
      U_IDLE: begin
        if (ready) begin
          st_n      = U_BUSY;
          sign_n    = a[31] ^ b[31];
          exp_n     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
          acc_n     = 48'h0;
          mcand_n   = {24'h0, ma_s} << tz_s;
          mplier_n  = mb_s >> tz_s;
          special_n = sp_s[32];
          res_n     = sp_s[31:0];
        end else begin
          st_n = U_IDLE;
        end
      end
      U_BUSY: begin
        if (special_r) begin
          st_n = U_DONE;
        end else begin
          acc_n    = acc_r + (mplier_r[0] ? mcand_r : 48'h0);
          mcand_n  = mcand_r << 1;
          mplier_n = mplier_r >> 1;
          if (mplier_r[23:1] == 23'h0) begin
            st_n  = U_DONE;
            res_n = fp_pack(sign_r, exp_r, acc_n);
          end else begin
            st_n = U_BUSY;
          end
        end
      end
      U_DONE: begin
        if (!ready) st_n = U_IDLE;
        else        st_n = U_DONE;
      end
      default: st_n = U_IDLE;
    endcase
  end

  // Unit state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_r      <= U_IDLE;
      acc_r     <= 48'h0;
      mcand_r   <= 48'h0;
      mplier_r  <= 24'h0;
      sign_r    <= 1'b0;
      exp_r     <= 10'sd0;
      special_r <= 1'b0;
      res_r     <= 32'h0;
    end else begin
      st_r      <= st_n;
      acc_r     <= acc_n;
      mcand_r   <= mcand_n;
      mplier_r  <= mplier_n;
      sign_r    <= sign_n;
      exp_r     <= exp_n;
      special_r <= special_n;
      res_r     <= res_n;
    end
  end

endmodule

module multi_multiplier #(
  parameter  int NUM_UNITS = 2,
  localparam int IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  input  logic [NUM_UNITS*32-1:0]  op1,
  input  logic [NUM_UNITS*32-1:0]  op2,
  output logic [31:0]              res,
  output logic                     res_valid,
  output logic [IDX_W-1:0]         res_idx,
  output logic                     done,
  output logic                     busy,
  output logic [2:0]               STATE
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_RUN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RET   = 3'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  state_t                  state_r, state_n;
  logic [NUM_UNITS*32-1:0] op1_r, op2_r;
  logic [NUM_UNITS-1:0]    rdy_r, rdy_n;
  logic [NUM_UNITS-1:0]    capt_r, capt_n;
  logic [NUM_UNITS-1:0]    cap_en_s;
  logic [31:0]             result_r [NUM_UNITS];
  logic [IDX_W-1:0]        cnt_r, cnt_n;
  logic                    ld_ops_s;
  logic [31:0]             res_r, res_n;
  logic [IDX_W-1:0]        res_idx_r, res_idx_n;
  logic                    res_valid_r, res_valid_n;
  logic                    done_r, done_n;
  logic                    busy_r, busy_n;
  logic [31:0]             unit_res_s [NUM_UNITS];
  logic [NUM_UNITS-1:0]    unit_done_s;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    verilog_multiplier u_mult (
      .clk   (clk),
      .rst   (rst),
      .ready (rdy_r[g]),
      .a     (op1_r[g*32 +: 32]),
      .b     (op2_r[g*32 +: 32]),
      .res   (unit_res_s[g]),
      .done  (unit_done_s[g])
    );
  end

  assign res       = res_r;
  assign res_valid = res_valid_r;
  assign res_idx   = res_idx_r;
  assign done      = done_r;
  assign busy      = busy_r;
  assign STATE     = state_r;

  // Next-state, unit start, capture and output-register values.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    rdy_n       = rdy_r;
    capt_n      = capt_r;
    cap_en_s    = '0;
    ld_ops_s    = 1'b0;
    res_n       = 32'h0;
    res_idx_n   = '0;
    res_valid_n = 1'b0;
    done_n      = 1'b0;
    case (state_r)
      ST_START: begin
        if (ready) begin
          ld_ops_s = 1'b1;
          capt_n   = '0;
          cnt_n    = '0;
          state_n  = ST_RUN;
`ifdef MULT_PARALLEL_START_EN
          rdy_n    = '1;
`else
          // Unit 0 starts on the acceptance edge so unit k starts k edges later.
          rdy_n    = '0;
          rdy_n[0] = 1'b1;
`endif
        end else begin
          state_n = ST_START;
        end
      end
      ST_RUN: begin
`ifdef MULT_PARALLEL_START_EN
        state_n = ST_WAIT;
        rdy_n   = '0;
`else
        if (cnt_r == LAST_IDX) begin
          state_n = ST_WAIT;
          rdy_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n        = cnt_r + IDX_W'(1);
          rdy_n[cnt_n] = 1'b1;
        end
`endif
      end
      ST_WAIT: begin
        if (&capt_r) begin
          state_n     = ST_RET;
          cnt_n       = '0;
          res_n       = result_r[0];
          res_idx_n   = '0;
          res_valid_n = 1'b1;
          done_n      = 1'b1;
        end else begin
          for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_done_s[k] && !capt_r[k]) begin
              cap_en_s[k] = 1'b1;
              capt_n[k]   = 1'b1;
            end else begin
              cap_en_s[k] = 1'b0;
            end
          end
        end
      end
      ST_RET: begin
        if (cnt_r == LAST_IDX) begin
          state_n = ST_START;
          cnt_n   = '0;
        end else begin
          cnt_n       = cnt_r + IDX_W'(1);
          res_n       = result_r[cnt_n];
          res_idx_n   = cnt_n;
          res_valid_n = 1'b1;
          done_n      = 1'b1;
        end
      end
      default: begin
        state_n = ST_START;
        rdy_n   = '0;
        cnt_n   = '0;
        capt_n  = '0;
      end
    endcase
    busy_n = (state_n != ST_START);
  end

  // Controller state, operand/result storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_START;
      op1_r       <= '0;
      op2_r       <= '0;
      rdy_r       <= '0;
      capt_r      <= '0;
      cnt_r       <= '0;
      res_r       <= 32'h0;
      res_idx_r   <= '0;
      res_valid_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      for (int k = 0; k < NUM_UNITS; k++) result_r[k] <= 32'h0;
    end else begin
      state_r     <= state_n;
      rdy_r       <= rdy_n;
      capt_r      <= capt_n;
      cnt_r       <= cnt_n;
      res_r       <= res_n;
      res_idx_r   <= res_idx_n;
      res_valid_r <= res_valid_n;
      done_r      <= done_n;
      busy_r      <= busy_n;
      if (ld_ops_s) begin
        op1_r <= op1;
        op2_r <= op2;
      end else begin
        op1_r <= op1_r;
        op2_r <= op2_r;
      end
      for (int k = 0; k < NUM_UNITS; k++) begin
        if (cap_en_s[k]) result_r[k] <= unit_res_s[k];
        else             result_r[k] <= result_r[k];
      end
    end
  end

endmodule

// File: tb/tb_multi_multiplier.sv
// Directed bench for multi_multiplier: a two-lane and a four-lane instance with hand-computed products.
module tb_multi_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ready2, ready4;
  logic [63:0]  op1_2, op2_2;
  logic [127:0] op1_4, op2_4;
  logic [31:0]  res2, res4;
  logic         res_valid2, res_valid4;
  logic [0:0]   res_idx2;
  logic [1:0]   res_idx4;
  logic         done2, done4, busy2, busy4;
  logic [2:0]   state2, state4;

  int n_total = 0;
  int n_pass  = 0;

`ifdef MULT_PARALLEL_START_EN
  localparam int RUN2 = 1;
  localparam int RUN4 = 1;
`else
  localparam int RUN2 = 2;
  localparam int RUN4 = 4;
`endif

  localparam logic [127:0] A4 = {32'h00000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] B4 = {32'h40A00000, 32'h40400000, 32'h40000000, 32'h3F800000};

  multi_multiplier #(.NUM_UNITS(2)) u2 (
    .clk(clk), .rst(rst), .ready(ready2), .op1(op1_2), .op2(op2_2),
    .res(res2), .res_valid(res_valid2), .res_idx(res_idx2),
    .done(done2), .busy(busy2), .STATE(state2)
  );

  multi_multiplier #(.NUM_UNITS(4)) u4 (
    .clk(clk), .rst(rst), .ready(ready4), .op1(op1_4), .op2(op2_4),
    .res(res4), .res_valid(res_valid4), .res_idx(res_idx4),
    .done(done4), .busy(busy4), .STATE(state4)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start4(input logic [127:0] a, input logic [127:0] b);
    op1_4 = a; op2_4 = b; ready4 = 1'b1;
    tick;
    ready4 = 1'b0;
    check("u4_state_run", {29'h0, state4}, 32'd1);
    repeat (RUN4 - 1) tick;
    check("u4_state_run_last", {29'h0, state4}, 32'd1);
    tick;
    check("u4_state_wait", {29'h0, state4}, 32'd2);
  endtask

  task automatic collect4(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_v [4];
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
    for (int c = 0; c < 200 && res_valid4 !== 1'b1; c++) begin
      check("u4_busy_wait", {31'h0, busy4}, 32'd1);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      check("u4_res_valid", {31'h0, res_valid4}, 32'd1);
      check("u4_res_idx", {30'h0, res_idx4}, 32'(i));
      check("u4_res", res4, exp_v[i]);
      check("u4_done", {31'h0, done4}, 32'd1);
      check("u4_busy_ret", {31'h0, busy4}, 32'd1);
      tick;
    end
    check("u4_done_fall", {31'h0, done4}, 32'd0);
    check("u4_valid_fall", {31'h0, res_valid4}, 32'd0);
    check("u4_busy_fall", {31'h0, busy4}, 32'd0);
    check("u4_state_idle", {29'h0, state4}, 32'd0);
  endtask

  task automatic start2(input logic [63:0] a, input logic [63:0] b);
    op1_2 = a; op2_2 = b; ready2 = 1'b1;
    tick;
    ready2 = 1'b0;
    check("u2_state_run", {29'h0, state2}, 32'd1);
    repeat (RUN2 - 1) tick;
    tick;
    check("u2_state_wait", {29'h0, state2}, 32'd2);
  endtask

  task automatic collect2(input logic [31:0] e0, input logic [31:0] e1);
    for (int c = 0; c < 200 && res_valid2 !== 1'b1; c++) begin
      check("u2_busy_wait", {31'h0, busy2}, 32'd1);
      tick;
    end
    check("u2_valid0", {31'h0, res_valid2}, 32'd1);
    check("u2_idx0", {31'h0, res_idx2}, 32'd0);
    check("u2_res0", res2, e0);
    check("u2_done0", {31'h0, done2}, 32'd1);
    tick;
    check("u2_valid1", {31'h0, res_valid2}, 32'd1);
    check("u2_idx1", {31'h0, res_idx2}, 32'd1);
    check("u2_res1", res2, e1);
    check("u2_done1", {31'h0, done2}, 32'd1);
    tick;
    check("u2_done_fall", {31'h0, done2}, 32'd0);
    check("u2_valid_fall", {31'h0, res_valid2}, 32'd0);
    check("u2_busy_fall", {31'h0, busy2}, 32'd0);
    check("u2_state_idle", {29'h0, state2}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; ready2 = 1'b0; ready4 = 1'b0;
    op1_2 = '0; op2_2 = '0; op1_4 = '0; op2_4 = '0;
    repeat (3) tick;
    check("rst_u4_res", res4, 32'h0);
    check("rst_u4_ctrl", {26'h0, res_valid4, res_idx4, done4, busy4}, 32'h0);
    check("rst_u4_state", {29'h0, state4}, 32'd0);
    check("rst_u2_ctrl", {27'h0, res_valid2, res_idx2, done2, busy2}, 32'h0);
    rst = 1'b0;
    tick;

    // Two-lane product
    start2({32'h40000000, 32'h3FC00000}, {32'h40400000, 32'h40000000});
    collect2(32'h40400000, 32'h40C00000);

    // Four lanes with mixed latency
    start4(A4, B4);
    collect4(32'h3F800000, 32'h40800000, 32'hC0400000, 32'h00000000);

    // Request while busy is ignored and not queued
    start4(A4, B4);
    op1_4 = {4{32'h40000000}}; op2_4 = {4{32'h40000000}}; ready4 = 1'b1;
    tick;
    ready4 = 1'b0;
    collect4(32'h3F800000, 32'h40800000, 32'hC0400000, 32'h00000000);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (state4 != 3'd0) seen++;
      tick;
    end
    check("u4_no_queued_batch", 32'(seen), 32'd0);

    // Reset in the middle of the wait phase
    start4(A4, B4);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_res", res4, 32'h0);
    check("mrst_ctrl", {26'h0, res_valid4, res_idx4, done4, busy4}, 32'h0);
    check("mrst_state", {29'h0, state4}, 32'd0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid4 === 1'b1) seen++;
      tick;
    end
    check("mrst_no_valid", 32'(seen), 32'd0);
    start4(A4, B4);
    collect4(32'h3F800000, 32'h40800000, 32'hC0400000, 32'h00000000);

    // Back-to-back batches with ready held high; operands changed after acceptance
    op1_2 = {32'h40000000, 32'h3FC00000}; op2_2 = {32'h40400000, 32'h40000000};
    ready2 = 1'b1;
    tick;
    check("b2b_accept1", {29'h0, state2}, 32'd1);
    op1_2 = {32'hBF800000, 32'h40400000}; op2_2 = {32'h3F000000, 32'h40400000};
    collect2(32'h40400000, 32'h40C00000);
    tick;
    check("b2b_accept2", {29'h0, state2}, 32'd1);
    check("b2b_done_gap", {31'h0, done2}, 32'd0);
    ready2 = 1'b0;
    collect2(32'h41100000, 32'hBF000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
